// File: rtl/butterfly_pkg.sv
// Shared types for the ButterFly memory arbiter: FSM states, owner tag and
// the registered bus request bundle.
package butterfly_pkg;

    typedef enum logic [1:0] {
        ARB_IDLE,
        ARB_REQ,
        ARB_RESP
    } arb_state_t;

    typedef enum logic {
        ARB_OWNER_IF,
        ARB_OWNER_D
    } arb_owner_t;

    typedef struct packed {
        logic        write;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  wstrb;
    } arb_bus_t;

endpackage

// File: rtl/mem_arb_watchdog.sv
// Cycle counter that flags a bus transaction which has been outstanding for
// TIMEOUT_CYCLES cycles; TIMEOUT_CYCLES = 0 disables it entirely.
module mem_arb_watchdog #(
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic clear_i,
    input  logic enable_i,
    output logic expired_o
);

    generate
        if (TIMEOUT_CYCLES == 0) begin : g_off
            logic unused_inputs;
            assign unused_inputs = ^{clk_i, rst_i, clear_i, enable_i};
            assign expired_o     = 1'b0;
        end else begin : g_on
            localparam int unsigned    CW   = $clog2(TIMEOUT_CYCLES + 1);
            localparam logic [CW-1:0]  LAST = CW'(TIMEOUT_CYCLES - 1);

            logic [CW-1:0] cnt_q, cnt_d;

            // cnt_q holds the number of completed cycles, so the current
            // cycle is the TIMEOUT_CYCLES-th one when cnt_q reaches LAST.
            always_comb begin
                cnt_d = cnt_q;
                if (clear_i) begin
                    cnt_d = '0;
                end else if (enable_i && (cnt_q != LAST)) begin
                    cnt_d = cnt_q + 1'b1;
                end
            end

            always_ff @(posedge clk_i) begin
                if (rst_i) begin
                    cnt_q <= '0;
                end else begin
                    cnt_q <= cnt_d;
                end
            end

            assign expired_o = enable_i && !clear_i && (cnt_q == LAST);
        end
    endgenerate

endmodule

// File: rtl/mem_arbiter.sv
// Shares the external memory bus between fetch and data ports: data has
// priority, fetch is guaranteed a grant after STARVE_LIMIT contested losses.
module mem_arbiter
    import butterfly_pkg::*;
#(
    parameter int unsigned STARVE_LIMIT   = 4,
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        if_req_i,
    input  logic [31:0] if_addr_i,
    output logic [31:0] if_rdata_o,
    output logic        if_ready_o,
    output logic        if_err_o,
    input  logic        d_req_i,
    input  logic        d_we_i,
    input  logic [31:0] d_addr_i,
    input  logic [31:0] d_wdata_i,
    input  logic [3:0]  d_wstrb_i,
    output logic [31:0] d_rdata_o,
    output logic        d_ready_o,
    output logic        d_err_o,
    output logic        mem_valid_o,
    output logic        mem_write_o,
    output logic [31:0] mem_addr_o,
    output logic [31:0] mem_wdata_o,
    output logic [3:0]  mem_wstrb_o,
    input  logic [31:0] mem_rdata_i,
    input  logic        mem_ready_i,
    output logic        busy_o
);

    localparam int unsigned   SW         = $clog2(STARVE_LIMIT + 1);
    localparam logic [SW-1:0] STARVE_MAX = SW'(STARVE_LIMIT);

    arb_state_t    state_q, state_d;
    arb_owner_t    owner_q, owner_d;
    arb_bus_t      bus_q, bus_d;
    logic [31:0]   rdata_q, rdata_d;
    logic          err_q, err_d;
    logic [SW-1:0] starve_q, starve_d;

    logic          wd_expired;
    logic          grant_data;
    logic          resp_if;
    logic          resp_d;

    mem_arb_watchdog #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_watchdog (
        .clk_i    (clk_i),
        .rst_i    (rst_i),
        .clear_i  (state_q != ARB_REQ),
        .enable_i (state_q == ARB_REQ),
        .expired_o(wd_expired)
    );

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= ARB_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ARB_IDLE: if (if_req_i || d_req_i)        state_d = ARB_REQ;
            ARB_REQ:  if (mem_ready_i || wd_expired)  state_d = ARB_RESP;
            ARB_RESP:                                 state_d = ARB_IDLE;
            default:                                  state_d = ARB_IDLE;
        endcase
    end

    assign grant_data = d_req_i && !(if_req_i && (starve_q == STARVE_MAX));

    always_comb begin
        owner_d  = owner_q;
        bus_d    = bus_q;
        rdata_d  = rdata_q;
        err_d    = err_q;
        starve_d = starve_q;
        case (state_q)
            ARB_IDLE: begin
                if (if_req_i || d_req_i) begin
                    rdata_d = '0;
                    err_d   = 1'b0;
                    if (grant_data) begin
                        owner_d     = ARB_OWNER_D;
                        bus_d.write = d_we_i;
                        bus_d.addr  = d_addr_i;
                        bus_d.wdata = d_we_i ? d_wdata_i : '0;
                        bus_d.wstrb = d_we_i ? d_wstrb_i : '0;
                        if (if_req_i && (starve_q != STARVE_MAX)) begin
                            starve_d = starve_q + 1'b1;
                        end
                    end else begin
                        owner_d     = ARB_OWNER_IF;
                        bus_d.write = 1'b0;
                        bus_d.addr  = if_addr_i;
                        bus_d.wdata = '0;
                        bus_d.wstrb = '0;
                        starve_d    = '0;
                    end
                end
            end
            // A ready on the expiry cycle still completes as OK.
            ARB_REQ: begin
                if (mem_ready_i) begin
                    rdata_d = bus_q.write ? '0 : mem_rdata_i;
                    err_d   = 1'b0;
                end else if (wd_expired) begin
                    rdata_d = '0;
                    err_d   = 1'b1;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            owner_q  <= ARB_OWNER_IF;
            bus_q    <= '0;
            rdata_q  <= '0;
            err_q    <= 1'b0;
            starve_q <= '0;
        end else begin
            owner_q  <= owner_d;
            bus_q    <= bus_d;
            rdata_q  <= rdata_d;
            err_q    <= err_d;
            starve_q <= starve_d;
        end
    end

    always_comb begin
        resp_if     = (state_q == ARB_RESP) && (owner_q == ARB_OWNER_IF);
        resp_d      = (state_q == ARB_RESP) && (owner_q == ARB_OWNER_D);
        busy_o      = (state_q != ARB_IDLE);
        mem_valid_o = (state_q == ARB_REQ);
        mem_write_o = bus_q.write;
        mem_addr_o  = bus_q.addr;
        mem_wdata_o = bus_q.wdata;
        mem_wstrb_o = bus_q.wstrb;
        if_ready_o  = resp_if && !err_q;
        if_err_o    = resp_if && err_q;
        if_rdata_o  = resp_if ? rdata_q : '0;
        d_ready_o   = resp_d && !err_q;
        d_err_o     = resp_d && err_q;
        d_rdata_o   = resp_d ? rdata_q : '0;
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: load/store timing, starvation rotation,
// watchdog abort, ready-on-expiry race and mid-transaction reset.
module tb_mem_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic        if_req;
    logic [31:0] if_addr;
    logic [31:0] if_rdata;
    logic        if_ready, if_err;
    logic        d_req, d_we;
    logic [31:0] d_addr, d_wdata, d_rdata;
    logic [3:0]  d_wstrb;
    logic        d_ready, d_err;
    logic        mem_valid, mem_write;
    logic [31:0] mem_addr, mem_wdata, mem_rdata;
    logic [3:0]  mem_wstrb;
    logic        mem_ready;
    logic        busy;

    int unsigned total = 0;
    int unsigned bad   = 0;

    always #5 clk = ~clk;

    mem_arbiter #(
        .STARVE_LIMIT  (4),
        .TIMEOUT_CYCLES(8)
    ) dut (
        .clk_i      (clk),
        .rst_i      (rst),
        .if_req_i   (if_req),
        .if_addr_i  (if_addr),
        .if_rdata_o (if_rdata),
        .if_ready_o (if_ready),
        .if_err_o   (if_err),
        .d_req_i    (d_req),
        .d_we_i     (d_we),
        .d_addr_i   (d_addr),
        .d_wdata_i  (d_wdata),
        .d_wstrb_i  (d_wstrb),
        .d_rdata_o  (d_rdata),
        .d_ready_o  (d_ready),
        .d_err_o    (d_err),
        .mem_valid_o(mem_valid),
        .mem_write_o(mem_write),
        .mem_addr_o (mem_addr),
        .mem_wdata_o(mem_wdata),
        .mem_wstrb_o(mem_wstrb),
        .mem_rdata_i(mem_rdata),
        .mem_ready_i(mem_ready),
        .busy_o     (busy)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        if_req    = 1'b0;
        if_addr   = '0;
        d_req     = 1'b0;
        d_we      = 1'b0;
        d_addr    = '0;
        d_wdata   = '0;
        d_wstrb   = '0;
        mem_rdata = '0;
        mem_ready = 1'b0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        step();
        step();
        rst = 1'b0;
    endtask

    logic [31:0]  grant_exp [10];
    int unsigned  vcnt, ecnt, rcnt, n;

    initial begin
        rst = 1'b1;
        clear_inputs();
        do_reset();

        // Reset state
        chk("rst_valid", 32'(mem_valid), 32'd0);
        chk("rst_busy",  32'(busy),      32'd0);
        chk("rst_addr",  mem_addr,       32'd0);
        chk("rst_dry",   32'(d_ready),   32'd0);
        chk("rst_ifry",  32'(if_ready),  32'd0);

        // Single load, zero-wait
        d_req  = 1'b1;
        d_we   = 1'b0;
        d_addr = 32'h0000_1000;
        step();
        chk("ld_valid", 32'(mem_valid), 32'd1);
        chk("ld_addr",  mem_addr,       32'h0000_1000);
        chk("ld_write", 32'(mem_write), 32'd0);
        chk("ld_wstrb", 32'(mem_wstrb), 32'd0);
        chk("ld_busy",  32'(busy),      32'd1);
        mem_ready = 1'b1;
        mem_rdata = 32'hDEAD_BEEF;
        step();
        chk("ld_ready", 32'(d_ready),   32'd1);
        chk("ld_rdata", d_rdata,        32'hDEAD_BEEF);
        chk("ld_vdrop", 32'(mem_valid), 32'd0);
        chk("ld_ifry",  32'(if_ready),  32'd0);
        chk("ld_ifrd",  if_rdata,       32'd0);
        chk("ld_wst2",  32'(mem_wstrb), 32'd0);
        d_req     = 1'b0;
        mem_ready = 1'b0;
        mem_rdata = '0;
        step();
        chk("ld_pulse1", 32'(d_ready), 32'd0);
        chk("ld_idle",   32'(busy),    32'd0);

        // Store with 3 wait cycles
        d_req   = 1'b1;
        d_we    = 1'b1;
        d_addr  = 32'h0000_0010;
        d_wdata = 32'h1234_5678;
        d_wstrb = 4'b0011;
        for (int i = 1; i <= 4; i++) begin
            step();
            chk($sformatf("st_valid%0d", i), 32'(mem_valid), 32'd1);
            chk($sformatf("st_addr%0d", i),  mem_addr,       32'h0000_0010);
            chk($sformatf("st_wdata%0d", i), mem_wdata,      32'h1234_5678);
            chk($sformatf("st_wstrb%0d", i), 32'(mem_wstrb), 32'd3);
            chk($sformatf("st_write%0d", i), 32'(mem_write), 32'd1);
            chk($sformatf("st_early%0d", i), 32'(d_ready),   32'd0);
            if (i == 4) begin
                mem_ready = 1'b1;
                mem_rdata = 32'hFFFF_FFFF;
            end
        end
        step();
        chk("st_ready", 32'(d_ready), 32'd1);
        chk("st_rdata", d_rdata,      32'd0);
        clear_inputs();
        step();
        chk("st_pulse1", 32'(d_ready), 32'd0);

        // Watchdog timeout: ready never comes
        d_req  = 1'b1;
        d_addr = 32'h0000_2000;
        vcnt = 0; ecnt = 0; rcnt = 0;
        for (int i = 0; i < 14; i++) begin
            step();
            if (mem_valid) vcnt++;
            if (d_ready) rcnt++;
            if (d_err) begin
                ecnt++;
                chk("to_rdata", d_rdata, 32'd0);
                d_req = 1'b0;
            end
        end
        chk("to_vcycles", 32'(vcnt), 32'd8);
        chk("to_errs",    32'(ecnt), 32'd1);
        chk("to_readys",  32'(rcnt), 32'd0);

        // Ready on the expiry cycle wins
        d_req  = 1'b1;
        d_addr = 32'h0000_3000;
        vcnt = 0; ecnt = 0; rcnt = 0;
        for (int i = 0; i < 14; i++) begin
            step();
            mem_ready = 1'b0;
            if (d_ready) begin
                rcnt++;
                chk("race_rdata", d_rdata, 32'hCAFE_F00D);
                d_req = 1'b0;
            end
            if (d_err) ecnt++;
            if (mem_valid) begin
                vcnt++;
                if (vcnt == 8) begin
                    mem_ready = 1'b1;
                    mem_rdata = 32'hCAFE_F00D;
                end
            end
        end
        chk("race_vcycles", 32'(vcnt), 32'd8);
        chk("race_readys",  32'(rcnt), 32'd1);
        chk("race_errs",    32'(ecnt), 32'd0);

        // Starvation rotation
        clear_inputs();
        do_reset();
        grant_exp = '{32'h200, 32'h200, 32'h200, 32'h200, 32'h100,
                      32'h200, 32'h200, 32'h200, 32'h200, 32'h100};
        if_req    = 1'b1;
        if_addr   = 32'h0000_0100;
        d_req     = 1'b1;
        d_addr    = 32'h0000_0200;
        mem_ready = 1'b1;
        mem_rdata = 32'h0000_0055;
        n = 0;
        for (int i = 0; i < 40 && n < 10; i++) begin
            step();
            if (mem_valid) begin
                chk($sformatf("grant%0d", n), mem_addr, grant_exp[n]);
                n++;
            end
        end
        chk("grant_count", 32'(n), 32'd10);
        if_req = 1'b0;
        d_req  = 1'b0;
        for (int i = 0; i < 4; i++) step();
        clear_inputs();
        step();

        // Reset in the middle of a fetch, request held through reset
        if_req  = 1'b1;
        if_addr = 32'h0000_0400;
        step();
        chk("mr_valid", 32'(mem_valid), 32'd1);
        chk("mr_addr",  mem_addr,       32'h0000_0400);
        rst       = 1'b1;
        mem_ready = 1'b1;
        mem_rdata = 32'h1111_1111;
        step();
        chk("mr_rvalid", 32'(mem_valid), 32'd0);
        chk("mr_rbusy",  32'(busy),      32'd0);
        chk("mr_raddr",  mem_addr,       32'd0);
        chk("mr_rifry",  32'(if_ready),  32'd0);
        chk("mr_riferr", 32'(if_err),    32'd0);
        chk("mr_rifrd",  if_rdata,       32'd0);
        rst       = 1'b0;
        mem_ready = 1'b0;
        step();
        chk("mr_regrant", 32'(mem_valid), 32'd1);
        chk("mr_readdr",  mem_addr,       32'h0000_0400);
        chk("mr_wstrb",   32'(mem_wstrb), 32'd0);
        mem_ready = 1'b1;
        mem_rdata = 32'hA5A5_5A5A;
        step();
        chk("mr_ifready", 32'(if_ready), 32'd1);
        chk("mr_ifrdata", if_rdata,      32'hA5A5_5A5A);
        chk("mr_dready",  32'(d_ready),  32'd0);
        chk("mr_drdata",  d_rdata,       32'd0);
        clear_inputs();
        step();
        chk("mr_pulse1", 32'(if_ready), 32'd0);
        chk("mr_idle",   32'(busy),     32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
